sdio_cmd53_sequencer: RTL
=========================

# sdio_cmd53_sequencer

Sequences CMD53 data transfers on the DAT0–DAT3 datapath. It sits between the command processor, which decodes CMD53 and holds the FBR block size, and the 4-bit data transmitter/receiver. Each accepted CMD53 (byte or block mode) is split into per-block transfers. For each block the sequencer issues one `write_data4_strobe` or `read_data4_strobe` pulse with the matching `data4_count`. It waits for the R5 response and inter-block gaps, and handles abort and CRC errors.

## Interface
Parameters:
- `START_DELAY`, 6: cycles after acceptance before the first block may start.
- `BLOCK_GAP`, 2: idle cycles between end of one block and the strobe of the next.

Ports (one clock; reset is synchronous and active-low):
- `clock`  in  1  system clock, all logic on rising edge.
- `reset_n`  in  1  synchronous active-low reset.
- `cmd_strobe`  in  1  one-cycle pulse: CMD53 for function 1 decoded.
- `cmd_write`  in  1  1 = host writes to card (receive on DAT), 0 = card to host (send).
- `cmd_block_mode`  in  1  1 = block mode, 0 = byte mode.
- `cmd_count`  in  9  byte count (byte mode) or block count (block mode).
- `block_size`  in  16  FBR function-1 block size; legal range 1..512.
- `abort`  in  1  one-cycle pulse: I/O Abort written for function 1.
- `send_command_in_progress`  in  1  R5 response currently being sent on CMD.
- `xfer_done`  in  1  one-cycle pulse from datapath: current block finished.
- `xfer_crc_error`  in  1  qualifies `xfer_done`: CRC error on a received block.
- `write_data4_strobe`  out  1  pulse: datapath sends `data4_count` bytes to host.
- `read_data4_strobe`  out  1  pulse: datapath receives `data4_count` bytes from host.
- `data4_count`  out  9  bytes in current block; value 0 encodes 512.
- `busy`  out  1  a transfer is active (state ≠ IDLE).
- `cmd_rejected`  out  1  pulse: `cmd_strobe` not accepted.
- `out_of_range`  out  1  sticky: rejected because `block_size` is illegal.
- `crc_error`  out  1  sticky: transfer stopped on receive CRC error.
- `blocks_left`  out  9  blocks still to start; 0 in byte mode and in infinite mode.

## Operation
- States: IDLE, START_WAIT, ISSUE, WAIT_DONE, GAP.
- Reset (`reset_n`=0 at an edge) puts the block in IDLE. All outputs go to 0, counters to 0, sticky flags cleared. This is legal in any state; no strobe is emitted on the following cycle.
- IDLE + `cmd_strobe`:
  - Block mode with `block_size`==0 or >512: stay in IDLE, pulse `cmd_rejected`, set `out_of_range`.
  - Otherwise: clear `out_of_range` and `crc_error`, latch direction, load the delay counter with `START_DELAY`, go to START_WAIT.
- Transfer size:
  - Byte mode: one block of `cmd_count` bytes (`cmd_count`=0 means 512).
  - Block mode: `data4_count` = `block_size[8:0]` (512 gives 0). `blocks_left` = `cmd_count`.
  - Block mode with `cmd_count`=0: infinite; runs until `abort`.
- START_WAIT: decrement the counter each cycle. Go to ISSUE in the cycle when counter==0 and `send_command_in_progress`==0.
- ISSUE: pulse the strobe for the latched direction for exactly 1 cycle. In finite block mode, decrement `blocks_left` in the same cycle. Then go to WAIT_DONE.
- WAIT_DONE, on `xfer_done`:
  - With `xfer_crc_error` (receive only): set `crc_error`, go to IDLE.
  - Else, if the last block is finished (byte mode, or `blocks_left`==0 in finite mode): go to IDLE.
  - Else: load the counter with `BLOCK_GAP`, go to GAP.
- GAP: count down. At 0 go to ISSUE (`send_command_in_progress` is ignored here).
- `abort` in any non-IDLE state: go to IDLE next cycle, `blocks_left`←0. It has priority over `xfer_done` in the same cycle. A strobe due that cycle is suppressed.
- `cmd_strobe` while `busy`: ignored, `cmd_rejected` pulses, state unchanged.
- `xfer_done` in IDLE, START_WAIT or GAP: ignored.

## Timing
- Minimum latency from `cmd_strobe` (cycle 0) to the first strobe is `START_DELAY`+1 cycles (cycle 7 by default), extended while `send_command_in_progress` is high.
- `data4_count` is stable from the strobe cycle until the next strobe or reset.
- From `xfer_done` (cycle n), the next strobe comes at cycle n+`BLOCK_GAP`+2.
- `busy` drops the cycle after the final `xfer_done` or `abort`, and can be re-accepted that cycle.
- `cmd_rejected` asserts the cycle after the offending `cmd_strobe`.

## Test plan
- Byte-mode send, `cmd_count`=4, `send_command_in_progress` low: one `write_data4_strobe` at cycle 7 with `data4_count`=4. Pulse `xfer_done` → `busy`=0 next cycle.
- Block-mode receive, `block_size`=512, `cmd_count`=3, `xfer_done` 20 cycles after each strobe: three `read_data4_strobe` pulses with `data4_count`=0, spaced 20+`BLOCK_GAP`+2 cycles apart; `blocks_left` goes 2,1,0.
- `block_size`=513 (then 0) with `cmd_strobe`: `cmd_rejected` pulse, `out_of_range`=1, no strobe ever. A next legal command clears `out_of_range`.
- Infinite block mode (`cmd_count`=0, `block_size`=64): 5 blocks complete, then `abort` during GAP → no further strobe, `busy`=0 next cycle.
- Receive with `xfer_crc_error` on block 2 of 4: `crc_error`=1, IDLE, no third strobe. A new `cmd_strobe` while busy earlier → `cmd_rejected`.
- `send_command_in_progress` held high 12 cycles after `cmd_strobe`: strobe delayed to the first cycle it is low. `reset_n`=0 during WAIT_DONE → all outputs 0; `xfer_done` afterwards ignored.

Source files
------------

// File: rtl/sdio_cmd53_sequencer.sv
// CMD53 transfer sequencer: splits an accepted byte/block-mode command into
// per-block strobes to the 4-bit DAT transmitter/receiver.
module sdio_cmd53_sequencer #(
    parameter int START_DELAY = 6,
    parameter int BLOCK_GAP   = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        cmd_strobe,
    input  logic        cmd_write,
    input  logic        cmd_block_mode,
    input  logic [8:0]  cmd_count,
    input  logic [15:0] block_size,
    input  logic        abort,
    input  logic        send_command_in_progress,
    input  logic        xfer_done,
    input  logic        xfer_crc_error,
    output logic        write_data4_strobe,
    output logic        read_data4_strobe,
    output logic [8:0]  data4_count,
    output logic        busy,
    output logic        cmd_rejected,
    output logic        out_of_range,
    output logic        crc_error,
    output logic [8:0]  blocks_left
);

    function automatic int sat_dec(input int v);
        return (v > 0) ? v - 1 : 0;
    endfunction

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int MAX_DELAY = max_of(START_DELAY, BLOCK_GAP);
    localparam int CNT_W     = (MAX_DELAY < 1) ? 1 : $clog2(MAX_DELAY + 1);

    // The decision cycle precedes ISSUE, so the start wait loads one less than
    // START_DELAY to put the first strobe START_DELAY+1 cycles after acceptance.
    localparam logic [CNT_W-1:0] START_LOAD = CNT_W'(sat_dec(START_DELAY));
    localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(BLOCK_GAP);

    typedef enum logic [2:0] {
        IDLE,
        START_WAIT,
        ISSUE,
        WAIT_DONE,
        GAP
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             dir_rx;
    logic             byte_mode;
    logic             infinite;
    logic [8:0]       blk_bytes;

    logic bad_size;
    logic accept;
    logic size_reject;
    logic busy_reject;
    logic issue_fire;
    logic crc_hit;
    logic abort_hit;

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        accept      = 1'b0;
        size_reject = 1'b0;
        busy_reject = 1'b0;
        issue_fire  = 1'b0;
        crc_hit     = 1'b0;
        abort_hit   = 1'b0;
        bad_size    = cmd_block_mode && ((block_size == 16'd0) || (block_size > 16'd512));

        case (state)
            IDLE: begin
                if (cmd_strobe) begin
                    if (bad_size) begin
                        size_reject = 1'b1;
                    end else begin
                        accept  = 1'b1;
                        cnt_n   = START_LOAD;
                        state_n = START_WAIT;
                    end
                end
            end
            START_WAIT: begin
                if (cnt == '0) begin
                    if (!send_command_in_progress) state_n = ISSUE;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            ISSUE: begin
                issue_fire = 1'b1;
                state_n    = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (xfer_done) begin
                    if (xfer_crc_error && dir_rx) begin
                        crc_hit = 1'b1;
                        state_n = IDLE;
                    end else if (byte_mode || (!infinite && blocks_left == 9'd0)) begin
                        state_n = IDLE;
                    end else begin
                        cnt_n   = GAP_LOAD;
                        state_n = GAP;
                    end
                end
            end
            GAP: begin
                if (cnt == '0) state_n = ISSUE;
                else           cnt_n   = cnt - CNT_W'(1);
            end
            default: state_n = IDLE;
        endcase

        // Abort outranks everything else in an active transfer, including a
        // strobe that would otherwise go out this cycle.
        if (state != IDLE) begin
            busy_reject = cmd_strobe;
            if (abort) begin
                abort_hit  = 1'b1;
                issue_fire = 1'b0;
                crc_hit    = 1'b0;
                state_n    = IDLE;
            end
        end
    end

    assign write_data4_strobe = issue_fire && !dir_rx;
    assign read_data4_strobe  = issue_fire && dir_rx;
    assign busy               = (state != IDLE);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state        <= IDLE;
            cnt          <= '0;
            dir_rx       <= 1'b0;
            byte_mode    <= 1'b0;
            infinite     <= 1'b0;
            blk_bytes    <= 9'd0;
            data4_count  <= 9'd0;
            blocks_left  <= 9'd0;
            cmd_rejected <= 1'b0;
            out_of_range <= 1'b0;
            crc_error    <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            cmd_rejected <= size_reject || busy_reject;

            if (size_reject) out_of_range <= 1'b1;

            if (accept) begin
                out_of_range <= 1'b0;
                crc_error    <= 1'b0;
                dir_rx       <= cmd_write;
                byte_mode    <= !cmd_block_mode;
                infinite     <= cmd_block_mode && (cmd_count == 9'd0);
                blk_bytes    <= cmd_block_mode ? block_size[8:0] : cmd_count;
                blocks_left  <= cmd_block_mode ? cmd_count : 9'd0;
            end

            if (crc_hit) crc_error <= 1'b1;

            // Size is presented from the strobe cycle and held until the next one.
            if (state_n == ISSUE) data4_count <= blk_bytes;

            if (issue_fire && !byte_mode && !infinite) blocks_left <= blocks_left - 9'd1;
            if (abort_hit) blocks_left <= 9'd0;
        end
    end

endmodule
